// File: rtl/joy_db15_responder.sv
// Device side of the DB15 joystick adapter: emulates a 74HC165 chain that
// holds two players' buttons and shifts them out to the host, active-low.
module joy_db15_responder #(
    parameter int NBITS       = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        joy_clk,
    input  logic        joy_load,
    input  logic [15:0] joystick1,
    input  logic [15:0] joystick2,
    output logic        joy_data,
    output logic        frame_done,
    output logic        overrun,
    output logic [4:0]  bit_cnt
);

    localparam int         FRAME   = 2 * NBITS;
    localparam logic [4:0] FRAME_C = 5'(FRAME);
    localparam logic [4:0] LAST_C  = 5'(FRAME - 1);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_load_sync;
    logic                   r_clk_d;
    logic [FRAME-1:0]       r_shreg;
    logic [4:0]             r_bit_cnt;
    logic                   r_frame_done;
    logic                   r_overrun;

    logic w_clk_s;
    logic w_load_s;
    logic w_rise;

    assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
    assign w_load_s = r_load_sync[SYNC_STAGES-1];
    assign w_rise   = w_clk_s & ~r_clk_d;

    // Host strobes idle high, so the synchronizers reset to 1 to avoid a
    // spurious edge or load right after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_sync  <= '1;
            r_load_sync <= '1;
            r_clk_d     <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], joy_clk};
            r_load_sync <= {r_load_sync[SYNC_STAGES-2:0], joy_load};
            r_clk_d     <= w_clk_s;
        end
    end

    // Load is transparent while held low; the last loaded cycle is the frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shreg      <= '1;
            r_bit_cnt    <= 5'd0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else if (!w_load_s) begin
            r_shreg      <= ~{joystick2[NBITS-1:0], joystick1[NBITS-1:0]};
            r_bit_cnt    <= 5'd0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_rise) begin
                r_shreg      <= {1'b1, r_shreg[FRAME-1:1]};
                r_frame_done <= (r_bit_cnt == LAST_C);
                if (r_bit_cnt < FRAME_C)
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                else
                    r_overrun <= 1'b1;
            end
        end
    end

    assign joy_data   = r_shreg[0];
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;
    assign bit_cnt    = r_bit_cnt;

endmodule

// File: tb/tb_joy_db15_responder.sv
// Bench for joy_db15_responder: host-side protocol driver with a frame model
// built from the button words and the count of host rises since load.
module tb_joy_db15_responder;

    localparam int NBITS = 12;
    localparam int SYNC  = 2;
    localparam int FRAME = 2 * NBITS;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        joy_clk = 1'b1;
    logic        joy_load = 1'b1;
    logic [15:0] joystick1 = 16'h0;
    logic [15:0] joystick2 = 16'h0;
    logic        joy_data;
    logic        frame_done;
    logic        overrun;
    logic [4:0]  bit_cnt;

    int n_chk = 0;
    int n_err = 0;
    int fd_cnt = 0;

    logic [15:0] m_j1 = 16'h0;
    logic [15:0] m_j2 = 16'h0;
    int          m_rises = 0;
    bit          m_loaded = 1'b0;

    joy_db15_responder #(.NBITS(NBITS), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset_n(reset_n), .joy_clk(joy_clk), .joy_load(joy_load),
        .joystick1(joystick1), .joystick2(joystick2), .joy_data(joy_data),
        .frame_done(frame_done), .overrun(overrun), .bit_cnt(bit_cnt)
    );

    always #10 clk = ~clk;

    always @(posedge clk) if (frame_done === 1'b1) fd_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit k of the frame as the host sees it: P1 buttons, P2 buttons, then idle ones.
    function automatic logic model_bit(input int k);
        if (!m_loaded || k >= FRAME) return 1'b1;
        if (k < NBITS) return ~m_j1[k];
        return ~m_j2[k - NBITS];
    endfunction

    function automatic int model_cnt();
        return (m_rises > FRAME) ? FRAME : m_rises;
    endfunction

    task automatic load_pulse(input logic [15:0] j1, input logic [15:0] j2, input bit with_rise);
        int fd0;
        @(negedge clk);
        fd0 = fd_cnt;
        if (with_rise) begin
            joy_clk = 1'b0;
            repeat (5) @(negedge clk);
        end
        joystick1 = j1;
        joystick2 = j2;
        joy_load  = 1'b0;
        joy_clk   = 1'b1;
        repeat (6) @(negedge clk);
        joy_load = 1'b1;
        repeat (6) @(negedge clk);
        m_j1 = j1; m_j2 = j2; m_rises = 0; m_loaded = 1'b1;
        chk("load_cnt", 32'(bit_cnt), 32'd0);
        chk("load_ovr", 32'(overrun), 32'd0);
        chk("load_data", 32'(joy_data), 32'(model_bit(0)));
        chk("load_nofd", 32'(fd_cnt - fd0), 32'd0);
    endtask

    task automatic shift_n(input int n);
        int fd0, r0;
        fd0 = fd_cnt;
        r0  = m_rises;
        for (int i = 0; i < n; i++) begin
            chk("data", 32'(joy_data), 32'(model_bit(m_rises)));
            joy_clk = 1'b0;
            repeat (5) @(negedge clk);
            joy_clk = 1'b1;
            repeat (5) @(negedge clk);
            m_rises++;
            chk("cnt", 32'(bit_cnt), 32'(model_cnt()));
        end
        chk("ovr", 32'(overrun), 32'(m_rises > FRAME));
        chk("fd_pulses", 32'(fd_cnt - fd0),
            32'((m_loaded && r0 < FRAME && m_rises >= FRAME) ? 1 : 0));
    endtask

    initial begin
        int lat;
        logic prev;

        // reset with inputs moving
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            joy_clk = $urandom_range(1, 0);
            joy_load = $urandom_range(1, 0);
            joystick1 = 16'($urandom);
            joystick2 = 16'($urandom);
            chk("rst_data", 32'(joy_data), 32'd1);
            chk("rst_cnt", 32'(bit_cnt), 32'd0);
            chk("rst_ovr", 32'(overrun), 32'd0);
            chk("rst_fd", 32'(frame_done), 32'd0);
        end
        joy_clk = 1'b1; joy_load = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("idle_data", 32'(joy_data), 32'd1);
            chk("idle_cnt", 32'(bit_cnt), 32'd0);
        end

        // directed full frame plus overrun
        load_pulse(16'h0005, 16'h0A00, 1'b0);
        shift_n(FRAME);
        chk("full_cnt", 32'(bit_cnt), 32'd24);
        shift_n(3);
        load_pulse(16'h0005, 16'h0A00, 1'b0);

        // capture freeze: inputs change after release
        load_pulse(16'h0001, 16'h0000, 1'b0);
        joystick1 = 16'h0000;
        shift_n(2);

        // abort after 7 rises, then a clean frame
        load_pulse(16'h1234, 16'h0FED, 1'b0);
        shift_n(7);
        load_pulse(16'h0ABC, 16'h0321, 1'b0);
        shift_n(FRAME);

        // rise coincident with load
        load_pulse(16'h0F0F, 16'h00F0, 1'b0);
        shift_n(4);
        load_pulse(16'h0555, 16'h0AAA, 1'b1);

        // latency from joy_clk rise to joy_data change (bit0=0 -> bit1=1)
        joy_clk = 1'b0;
        repeat (5) @(negedge clk);
        prev = joy_data;
        joy_clk = 1'b1;
        lat = 0;
        while (joy_data === prev && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(SYNC + 1));
        repeat (5) @(negedge clk);
        m_rises++;
        shift_n(FRAME - 1);

        // random frames, including partial frames and overruns
        for (int t = 0; t < 8; t++) begin
            load_pulse(16'($urandom), 16'($urandom), 1'($urandom_range(1, 0)));
            shift_n($urandom_range(FRAME + 3, 0));
        end

        // async reset mid-frame with a pressed bit on the line
        load_pulse(16'hFFFF, 16'hFFFF, 1'b0);
        shift_n(5);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_data", 32'(joy_data), 32'd1);
        chk("arst_cnt", 32'(bit_cnt), 32'd0);
        chk("arst_ovr", 32'(overrun), 32'd0);
        chk("arst_fd", 32'(frame_done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        m_loaded = 1'b0; m_rises = 0;
        shift_n(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/joy_db15_responder.md
Name: joy_db15_responder

Overview:
- Device-side model of the DB15 serial joystick adapter: the other end of the host-side joy_db15 reader.
- The host drives JOY_LOAD and JOY_CLK. This block latches two players' button states and shifts them out on JOY_DATA with 74HC165-chain semantics.
- Used as a bench responder for the joy_db15 path. Also used as a synthesizable adapter when a second MiSTer or FPGA board emulates the DB15 pad pair.

Parameters:
- NBITS, 12, bits per player shifted in a frame (1..15). Frame length is 2*NBITS.
- SYNC_STAGES, 2, synchronizer depth on joy_clk and joy_load (>=2).

Ports:
- clk  in  1  system clock, 40-50 MHz. Host joy_clk rate must be <= clk/8.
- reset_n  in  1  asynchronous active-low reset.
- joy_clk  in  1  host shift clock, asynchronous to clk, idle high.
- joy_load  in  1  host parallel-load strobe, asynchronous, active-low.
- joystick1  in  16  player 1 buttons, active-high pressed, map LS FEDCBAUDLR (bit0=R). Bits [NBITS-1:0] are used.
- joystick2  in  16  player 2 buttons, same map.
- joy_data  out  1  serial data to host, active-low (0 = pressed). Registered.
- frame_done  out  1  one-cycle pulse when the last frame bit has been shifted past.
- overrun  out  1  sticky. Set when the host clocks beyond the frame. Cleared by load.
- bit_cnt  out  5  number of shifts since the last load, saturating at 2*NBITS.

Behaviour:
- Reset (async, reset_n=0):
  - All synchronizer flops = 1; shreg = all ones; joy_data = 1.
  - bit_cnt = 0; frame_done = 0; overrun = 0.
  - Release is taken synchronously to clk.
- Sync: joy_clk and joy_load each pass through SYNC_STAGES flops (clk_s, load_s). One extra flop of clk_s gives rise = clk_s & ~clk_d.
- shreg is 2*NBITS wide. joy_data = shreg[0], registered, with no combinational path from the inputs.
- LOAD state (load_s==0), every cycle:
  - shreg <= ~{joystick2[NBITS-1:0], joystick1[NBITS-1:0]} (transparent, like a 165 with PL low).
  - bit_cnt <= 0; overrun <= 0; frame_done <= 0.
  - joy_clk edges are ignored.
- Capture: the value seen on the last cycle before load_s returns to 1 is the frame content. Input changes after that cycle do not affect the frame.
- SHIFT state (load_s==1) on rise:
  - shreg <= {1'b1, shreg[2*NBITS-1:1]}, so ones fill from the serial input.
  - If bit_cnt < 2*NBITS: bit_cnt+1.
  - If bit_cnt == 2*NBITS-1 before the increment: frame_done = 1 for exactly one cycle.
  - If bit_cnt == 2*NBITS already: overrun <= 1, bit_cnt holds, joy_data stays 1.
- Bit order on joy_data:
  - First bit, available right after load: P1 bit0 (R).
  - Then P1 bit1..bit(NBITS-1), then P2 bit0..bit(NBITS-1), then constant 1.
- Latency: host edge on joy_clk or joy_load to updated joy_data is SYNC_STAGES+1 clk cycles (3 at default). Guaranteed within 4 clk.
- Simultaneous events:
  - rise in the same cycle as load_s==0: load wins, no shift, no count.
  - load falling mid-frame aborts the frame: reload, bit_cnt=0, no frame_done.
- No other FSM state exists. Mode is a pure function of load_s.
- Falling edges of joy_clk have no effect.
- Reset asserted mid-frame: immediate return to reset values. The next frame requires a new load.

Test Plan:
- Reset: reset_n=0 with inputs toggling -> joy_data=1, bit_cnt=0, overrun=0, frame_done=0. After release with no host activity, all stay constant.
- Full frame: joystick1=16'h0005, joystick2=16'h0A00, load pulse, then 24 clocks at clk/10 -> host samples (before each rise) 0,1,0,1,1,1,1,1,1,1,1,1 then 1,1,1,1,1,1,1,1,1,0,1,0 (active-low). frame_done pulses once after the 24th rise; bit_cnt=24.
- Overrun: 3 extra rises after the frame -> joy_data=1, bit_cnt=24, overrun=1. Next load -> overrun=0, bit_cnt=0.
- Capture freeze: change joystick1 from 16'h0001 to 16'h0000 one host-clock after load release -> first bit still 0 (pressed).
- Abort: load after 7 rises -> bit_cnt=0, joy_data=~joystick1[0], no frame_done. A new 24-bit frame reads correctly.
- Simultaneous/latency: drive joy_clk rise coincident with joy_load low -> no shift. Measure joy_data update <= 4 clk after a joy_clk edge. Assert reset_n=0 mid-frame -> all outputs at reset values asynchronously.
